// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
//   Shared definitions for the two-lane traffic phase controller:
//     - tlc_state_e : fixed-width (4-bit) binary state encoding
//     - lamps_t     : packed lamp bundle {A r/y/g, B r/y/g, walk}
//     - DEF_*       : default phase durations in seconds (one clock = 1 s)
//     - decode_lamps: Moore lamp decode for a given state and blink phase
//   Optional feature macro: TLC_PED_WALK_EN (enables the PED_WALK lamp decode).
// -----------------------------------------------------------------------------
package tlc_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_ALLRED_INIT = 4'd0,
      ST_A_GREEN     = 4'd1,
      ST_A_YELLOW    = 4'd2,
      ST_ALLRED_AB   = 4'd3,
      ST_B_GREEN     = 4'd4,
      ST_B_YELLOW    = 4'd5,
      ST_ALLRED_BA   = 4'd6,
      ST_NIGHT       = 4'd7,
      ST_PED_WALK    = 4'd8
   } tlc_state_e;

   // Default phase durations, shared with the display and top level.
   localparam int DEF_GREEN_A_SEC = 25;
   localparam int DEF_GREEN_B_SEC = 20;
   localparam int DEF_YELLOW_SEC  = 3;
   localparam int DEF_ALLRED_SEC  = 2;
   localparam int DEF_WALK_SEC    = 10;
   localparam int DEF_CNT_W       = 6;

   typedef struct packed {
      logic a_red;
      logic a_yellow;
      logic a_green;
      logic b_red;
      logic b_yellow;
      logic b_green;
      logic walk;
   } lamps_t;

   localparam lamps_t LAMPS_ALL_RED = '{a_red: 1'b1, b_red: 1'b1, default: 1'b0};

   // Lamp pattern for a state. Any code without a lit phase (all-red states
   // and unused encodings) shows both reds, so a corrupted state is fail-safe.
   function automatic lamps_t decode_lamps(input tlc_state_e st, input logic blink);
      lamps_t l;
      l = '0;
      case (st)
         ST_A_GREEN: begin
            l.a_green = 1'b1;
            l.b_red   = 1'b1;
         end
         ST_A_YELLOW: begin
            l.a_yellow = 1'b1;
            l.b_red    = 1'b1;
         end
         ST_B_GREEN: begin
            l.b_green = 1'b1;
            l.a_red   = 1'b1;
         end
         ST_B_YELLOW: begin
            l.b_yellow = 1'b1;
            l.a_red    = 1'b1;
         end
         ST_NIGHT: begin
            l.a_yellow = blink;
            l.b_yellow = blink;
         end
`ifdef TLC_PED_WALK_EN
         ST_PED_WALK: begin
            l.a_red = 1'b1;
            l.b_red = 1'b1;
            l.walk  = 1'b1;
         end
`endif
         default: l = LAMPS_ALL_RED;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   CNT_W-bit loadable down-counter used as the phase timer.
//   load has priority over counting; counting saturates at zero.
// Ports:
//   clk        in  1      clock
//   rst        in  1      asynchronous active-high reset (value <= RESET_VALUE)
//   load       in  1      load load_value this clock
//   load_value in  CNT_W  value to load
//   dec_en     in  1      decrement enable (ignored while load=1)
//   value      out CNT_W  current count
//   zero       out 1      value == 0
// -----------------------------------------------------------------------------
module phase_timer #(
   parameter int               CNT_W       = 6,
   parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec_en,
   output logic [CNT_W-1:0] value,
   output logic             zero
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_value;
      end else if (dec_en && (value_q != '0)) begin
         value_d = value_q - ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= RESET_VALUE;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign zero  = (value_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
//   Master sequencer for a two-lane intersection running on a 1 Hz clock
//   (one clock = one second). Cycles lane A / lane B through green, yellow and
//   all-red clearance phases, handles night mode (both yellows blinking) and
//   reports the seconds left in the current phase.
//
//   Optional feature macro: TLC_PED_WALK_EN
//     defined   : ped_req is latched; a PED_WALK phase (both reds + walk lamp)
//                 is inserted after ALLRED_BA when a request is pending.
//     undefined : no walk phase, ped_req unused, ped_walk tied to 0.
//
// Ports:
//   clk_1hz      in  1      1 Hz clock, all state on its rising edge
//   reset        in  1      asynchronous active-high reset
//   night_req    in  1      level, 1 = night mode requested
//   ped_req      in  1      pedestrian request (pulse or level)
//   laneA_red/yellow/green  out 1  lane A lamps
//   laneB_red/yellow/green  out 1  lane B lamps
//   ped_walk     out 1      walk lamp
//   countdown    out CNT_W  seconds left in the phase (incl. current); 0 in NIGHT
//
// Lamps are registered from the next-state decode, so they change on the same
// edge as the state register and have no extra latency.
// -----------------------------------------------------------------------------
module traffic_phase_controller
   import tlc_pkg::*;
#(
   parameter int GREEN_A_SEC = DEF_GREEN_A_SEC,
   parameter int GREEN_B_SEC = DEF_GREEN_B_SEC,
   parameter int YELLOW_SEC  = DEF_YELLOW_SEC,
   parameter int ALLRED_SEC  = DEF_ALLRED_SEC,
   parameter int WALK_SEC    = DEF_WALK_SEC,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk_1hz,
   input  logic             reset,
   input  logic             night_req,
   input  logic             ped_req,
   output logic             laneA_red,
   output logic             laneA_yellow,
   output logic             laneA_green,
   output logic             laneB_red,
   output logic             laneB_yellow,
   output logic             laneB_green,
   output logic             ped_walk,
   output logic [CNT_W-1:0] countdown
);

   // Timer load values: the timer holds "seconds left minus one".
   localparam logic [CNT_W-1:0] GA_LOAD   = CNT_W'(GREEN_A_SEC - 1);
   localparam logic [CNT_W-1:0] GB_LOAD   = CNT_W'(GREEN_B_SEC - 1);
   localparam logic [CNT_W-1:0] YL_LOAD   = CNT_W'(YELLOW_SEC - 1);
   localparam logic [CNT_W-1:0] AR_LOAD   = CNT_W'(ALLRED_SEC - 1);
   localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_SEC - 1);
   localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

   tlc_state_e       state_q;
   tlc_state_e       state_d;
   logic             blink_q;
   logic             blink_d;
   lamps_t           lamps_q;
   lamps_t           lamps_d;

   logic             timer_load;
   logic [CNT_W-1:0] timer_load_value;
   logic             timer_dec_en;
   logic [CNT_W-1:0] timer_value;
   logic             timer_zero;

`ifdef TLC_PED_WALK_EN
   logic             ped_latch_q;
   logic             ped_latch_d;
`endif

   // ---------------------------------------------------------------------------
   // Phase timer
   // ---------------------------------------------------------------------------
   phase_timer #(
      .CNT_W      (CNT_W),
      .RESET_VALUE(AR_LOAD)
   ) u_phase_timer (
      .clk       (clk_1hz),
      .rst       (reset),
      .load      (timer_load),
      .load_value(timer_load_value),
      .dec_en    (timer_dec_en),
      .value     (timer_value),
      .zero      (timer_zero)
   );

   // ---------------------------------------------------------------------------
   // Next-state logic. night_req outranks timer expiry in the greens; in the
   // yellow/all-red sequence the night decision is made only at all-red expiry.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ALLRED_INIT: begin
            if (timer_zero) state_d = night_req ? ST_NIGHT : ST_A_GREEN;
         end
         ST_A_GREEN: begin
            if (night_req || timer_zero) state_d = ST_A_YELLOW;
         end
         ST_A_YELLOW: begin
            if (timer_zero) state_d = ST_ALLRED_AB;
         end
         ST_ALLRED_AB: begin
            if (timer_zero) state_d = night_req ? ST_NIGHT : ST_B_GREEN;
         end
         ST_B_GREEN: begin
            if (night_req || timer_zero) state_d = ST_B_YELLOW;
         end
         ST_B_YELLOW: begin
            if (timer_zero) state_d = ST_ALLRED_BA;
         end
         ST_ALLRED_BA: begin
            if (timer_zero) begin
               if (night_req) state_d = ST_NIGHT;
`ifdef TLC_PED_WALK_EN
               else if (ped_latch_q) state_d = ST_PED_WALK;
`endif
               else state_d = ST_A_GREEN;
            end
         end
         ST_NIGHT: begin
            if (!night_req) state_d = ST_ALLRED_BA;
         end
`ifdef TLC_PED_WALK_EN
         // Night arriving during a walk goes straight to NIGHT so no green
         // is ever entered with night_req high.
         ST_PED_WALK: begin
            if (timer_zero) state_d = night_req ? ST_NIGHT : ST_A_GREEN;
         end
`endif
         default: state_d = ST_ALLRED_INIT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Timer control: reload on every state change with the new phase length.
   // NIGHT loads zero and holds there.
   // ---------------------------------------------------------------------------
   always_comb begin
      timer_load       = (state_d != state_q);
      timer_dec_en     = (state_q != ST_NIGHT);
      timer_load_value = '0;
      case (state_d)
         ST_A_GREEN:     timer_load_value = GA_LOAD;
         ST_B_GREEN:     timer_load_value = GB_LOAD;
         ST_A_YELLOW,
         ST_B_YELLOW:    timer_load_value = YL_LOAD;
         ST_ALLRED_INIT,
         ST_ALLRED_AB,
         ST_ALLRED_BA:   timer_load_value = AR_LOAD;
`ifdef TLC_PED_WALK_EN
         ST_PED_WALK:    timer_load_value = WALK_LOAD;
`endif
         default:        timer_load_value = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Blink: cleared on NIGHT entry, toggles each clock while staying in NIGHT.
   // ---------------------------------------------------------------------------
   always_comb begin
      blink_d = (state_d == ST_NIGHT) && (state_q == ST_NIGHT) && !blink_q;
      lamps_d = decode_lamps(state_d, blink_d);
   end

`ifdef TLC_PED_WALK_EN
   // Sticky pedestrian request. Cleared when the walk phase is entered, so a
   // press during the walk is kept for the next cycle. Ignored in NIGHT.
   always_comb begin
      ped_latch_d = ped_latch_q;
      if (ped_req && (state_q != ST_NIGHT)) ped_latch_d = 1'b1;
      if ((state_q != ST_PED_WALK) && (state_d == ST_PED_WALK)) ped_latch_d = 1'b0;
   end
`endif

   // ---------------------------------------------------------------------------
   // FSM state, blink, ped latch and registered lamp outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_1hz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_ALLRED_INIT;
         blink_q     <= 1'b0;
         lamps_q     <= LAMPS_ALL_RED;
`ifdef TLC_PED_WALK_EN
         ped_latch_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         blink_q     <= blink_d;
         lamps_q     <= lamps_d;
`ifdef TLC_PED_WALK_EN
         ped_latch_q <= ped_latch_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign laneA_red    = lamps_q.a_red;
   assign laneA_yellow = lamps_q.a_yellow;
   assign laneA_green  = lamps_q.a_green;
   assign laneB_red    = lamps_q.b_red;
   assign laneB_yellow = lamps_q.b_yellow;
   assign laneB_green  = lamps_q.b_green;
   assign countdown    = (state_q == ST_NIGHT) ? '0 : (timer_value + ONE);

`ifdef TLC_PED_WALK_EN
   assign ped_walk = lamps_q.walk;
`else
   logic [2:0] unused_cfg;
   assign unused_cfg = {ped_req, lamps_q.walk, WALK_LOAD[0]};
   assign ped_walk   = 1'b0;
`endif

   // Lamp safety: never two greens, never a green beside the other lane's non-red.
   always_comb begin
      assert (!(lamps_q.a_green && lamps_q.b_green));
      assert (!(lamps_q.a_green && !lamps_q.b_red));
      assert (!(lamps_q.b_green && !lamps_q.a_red));
   end

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

  localparam int GA = 5;
  localparam int GB = 4;
  localparam int YL = 2;
  localparam int AR = 1;
  localparam int WK = 3;
  localparam int CW = 6;

  // lamp vector bits: {A red, A yellow, A green, B red, B yellow, B green, walk}
  localparam logic [6:0] L_AG = 7'b0011000;
  localparam logic [6:0] L_AY = 7'b0101000;
  localparam logic [6:0] L_BG = 7'b1000010;
  localparam logic [6:0] L_BY = 7'b1000100;
  localparam logic [6:0] L_RR = 7'b1001000;
  localparam logic [6:0] L_N0 = 7'b0000000;
  localparam logic [6:0] L_N1 = 7'b0100100;
  localparam logic [6:0] L_PW = 7'b1001001;

  typedef struct {
    logic          night;
    logic          ped;
    logic [6:0]    lamps;
    logic [CW-1:0] cd;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          night_req;
  logic          ped_req;
  logic          a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk;
  logic [CW-1:0] countdown;
  logic [6:0]    lamps;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  traffic_phase_controller #(
    .GREEN_A_SEC(GA), .GREEN_B_SEC(GB), .YELLOW_SEC(YL),
    .ALLRED_SEC(AR), .WALK_SEC(WK), .CNT_W(CW)
  ) dut (
    .clk_1hz     (clk),
    .reset       (reset),
    .night_req   (night_req),
    .ped_req     (ped_req),
    .laneA_red   (a_red),
    .laneA_yellow(a_yellow),
    .laneA_green (a_green),
    .laneB_red   (b_red),
    .laneB_yellow(b_yellow),
    .laneB_green (b_green),
    .ped_walk    (walk),
    .countdown   (countdown)
  );

  assign lamps = {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // checking helpers
  task automatic check_out(input string name, input logic [6:0] exp_l, input logic [CW-1:0] exp_c);
    checks++;
    if (lamps !== exp_l || countdown !== exp_c) begin
      errors++;
      $display("FAIL %s: lamps=%b countdown=%0d, expected lamps=%b countdown=%0d",
               name, lamps, countdown, exp_l, exp_c);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic add_vec(input logic n, input logic p, input logic [6:0] l, input int c);
    vec_t v;
    v.night = n;
    v.ped   = p;
    v.lamps = l;
    v.cd    = CW'(c);
    vq.push_back(v);
  endtask

  task automatic add_run(input logic n, input logic [6:0] l, input int from);
    for (int c = from; c >= 1; c--) add_vec(n, 1'b0, l, c);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      night_req = vq[i].night;
      ped_req   = vq[i].ped;
      @(posedge clk);
      #1;
      check_out($sformatf("%s[%0d]", tag, i), vq[i].lamps, vq[i].cd);
      @(negedge clk);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    night_req = 1'b0;
    ped_req   = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int dur(input logic [6:0] l);
    case (l)
      L_AG:       return GA;
      L_BG:       return GB;
      L_AY, L_BY: return YL;
      L_RR:       return AR;
      L_PW:       return WK;
      default:    return 0;
    endcase
  endfunction

  initial begin
    logic [6:0] prev;
    logic [6:0] cur;
    int         prev_cd;
    int         cur_cd;
    logic       n;
    bit         legal;

    reset     = 1'b1;
    night_req = 1'b0;
    ped_req   = 1'b0;

    // reset state, before any clock edge
    #1;
    check_out("reset_state", L_RR, AR);
    @(posedge clk);
    @(negedge clk);
    check_out("reset_held", L_RR, AR);
    reset = 1'b0;

    // tests 1-3: normal cycle, night entry from A green, night exit
    add_run(0, L_AG, GA);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_run(0, L_BG, GB);
    add_run(0, L_BY, YL);
    add_run(0, L_RR, AR);
    add_vec(0, 0, L_AG, 5);
    add_vec(0, 0, L_AG, 4);
    add_vec(1, 0, L_AY, 2);
    add_vec(1, 0, L_AY, 1);
    add_vec(1, 0, L_RR, 1);
    add_vec(1, 0, L_N0, 0);
    add_vec(1, 0, L_N1, 0);
    add_vec(1, 0, L_N0, 0);
    add_vec(1, 0, L_N1, 0);
    add_vec(0, 0, L_RR, 1);
    add_run(0, L_AG, GA);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_vec(0, 0, L_BG, 4);
    add_vec(0, 0, L_BG, 3);
    run_table("cycle_night");

    // test 4: asynchronous reset in B green
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_out("reset_async_mid_b_green", L_RR, AR);
    @(posedge clk);
    #1;
    check_out("reset_hold_mid", L_RR, AR);
    @(negedge clk);
    reset = 1'b0;
    add_run(0, L_AG, GA);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_vec(0, 0, L_BG, 4);
    run_table("restart");

    // test 6: pedestrian pulse in A green, second pulse during the walk
    do_reset();
    add_vec(0, 0, L_AG, 5);
    add_vec(0, 1, L_AG, 4);
    add_run(0, L_AG, 3);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_run(0, L_BG, GB);
    add_run(0, L_BY, YL);
    add_run(0, L_RR, AR);
`ifdef TLC_PED_WALK_EN
    add_vec(0, 0, L_PW, 3);
    add_vec(0, 1, L_PW, 2);
    add_vec(0, 0, L_PW, 1);
    add_run(0, L_AG, GA);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_run(0, L_BG, GB);
    add_run(0, L_BY, YL);
    add_run(0, L_RR, AR);
    add_run(0, L_PW, WK);
    add_vec(0, 0, L_AG, 5);
`else
    add_vec(0, 0, L_AG, 5);
    add_vec(0, 1, L_AG, 4);
    add_run(0, L_AG, 3);
    add_run(0, L_AY, YL);
    add_run(0, L_RR, AR);
    add_run(0, L_BG, GB);
    add_run(0, L_BY, YL);
    add_run(0, L_RR, AR);
    add_vec(0, 0, L_AG, 5);
`endif
    run_table("ped");

    // test 5: random night_req / ped_req with phase-rule checks
    do_reset();
    prev    = L_RR;
    prev_cd = AR;
    n       = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 15) == 0) n = !n;
      night_req = n;
      ped_req   = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      #1;
      cur    = lamps;
      cur_cd = int'(countdown);
      legal  = !(cur[4] && cur[1]) && !(cur[4] && !cur[3]) && !(cur[1] && !cur[6]);
      check_val("rnd_legal", int'(legal), 1);
      if (!cur[6] && !cur[3]) begin
        check_val("rnd_night_cd", cur_cd, 0);
        check_val("rnd_night_yellows_equal", int'(cur[5]), int'(cur[2]));
        if (!prev[6] && !prev[3]) begin
          check_val("rnd_blink_toggle", int'(cur[5]), int'(!prev[5]));
        end else begin
          check_val("rnd_night_from_clear", int'(prev == L_RR || prev == L_PW), 1);
          check_val("rnd_blink_first_off", int'(cur[5]), 0);
        end
      end else if ((prev[6] || prev[3]) && (prev == L_AG || prev == L_BG) && n) begin
        check_val("rnd_green_abort_lamps", int'(cur), int'((prev == L_AG) ? L_AY : L_BY));
        check_val("rnd_green_abort_cd", cur_cd, YL);
      end else if (cur == prev && (prev[6] || prev[3])) begin
        check_val("rnd_cd_step", cur_cd, prev_cd - 1);
      end else begin
        check_val("rnd_phase_len", cur_cd, dur(cur));
        if (prev[6] || prev[3]) check_val("rnd_prev_expired", prev_cd, 1);
        else check_val("rnd_night_exit_allred", int'(cur), int'(L_RR));
        if (cur[4] || cur[1]) check_val("rnd_green_no_night", int'(n), 0);
      end
      prev    = cur;
      prev_cd = cur_cd;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
